// File: rtl/pe_pkg.sv
// Shared definitions for the flexible systolic processing element:
// FSM states, dataflow mode encodings and accumulator range helpers.
package pe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OS_RUN,
        ST_OS_DRAIN,
        ST_WS_LOAD,
        ST_WS_RUN
    } pe_state_t;

    localparam logic MODE_OS = 1'b0;
    localparam logic MODE_WS = 1'b1;

    function automatic longint acc_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint acc_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/pe_mac_sat.sv
// Combinational extend-multiply-add with optional clamp to the signed
// accumulator range; shared by the output- and weight-stationary paths.
module pe_mac_sat
    import pe_pkg::*;
#(
    parameter int OPND_BWIDTH = 8,
    parameter int ACC_BWIDTH  = 32,
    parameter bit SATURATE    = 1'b1
) (
    input  logic [OPND_BWIDTH-1:0] i_a,
    input  logic [OPND_BWIDTH-1:0] i_b,
    input  logic [ACC_BWIDTH-1:0]  i_acc,
    input  logic                   i_signed,
    output logic [ACC_BWIDTH-1:0]  o_sum,
    output logic                   o_sat
);
    // One guard bit beyond ACC+1 keeps the clamp direction right when
    // ACC_BWIDTH is only 2*OPND_BWIDTH and a near-max sum meets a big product.
    localparam int SW = ACC_BWIDTH + 2;
    localparam logic signed [SW-1:0] MAX_V = SW'(acc_max(ACC_BWIDTH));
    localparam logic signed [SW-1:0] MIN_V = SW'(acc_min(ACC_BWIDTH));

    logic signed [OPND_BWIDTH:0] w_a_x;
    logic signed [OPND_BWIDTH:0] w_b_x;
    logic signed [SW-1:0]        w_a_w;
    logic signed [SW-1:0]        w_b_w;
    logic signed [SW-1:0]        w_prod;
    logic signed [SW-1:0]        w_acc_w;
    logic signed [SW-1:0]        w_sum;

    assign w_a_x   = {i_signed & i_a[OPND_BWIDTH-1], i_a};
    assign w_b_x   = {i_signed & i_b[OPND_BWIDTH-1], i_b};
    assign w_a_w   = {{(SW-OPND_BWIDTH-1){w_a_x[OPND_BWIDTH]}}, w_a_x};
    assign w_b_w   = {{(SW-OPND_BWIDTH-1){w_b_x[OPND_BWIDTH]}}, w_b_x};
    assign w_prod  = w_a_w * w_b_w;
    assign w_acc_w = {{2{i_acc[ACC_BWIDTH-1]}}, i_acc};
    assign w_sum   = w_acc_w + w_prod;

    // NOTE: both outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        o_sum = w_sum[ACC_BWIDTH-1:0];
        o_sat = 1'b0;
        if (SATURATE) begin
            if (w_sum > MAX_V) begin
                o_sum = MAX_V[ACC_BWIDTH-1:0];
                o_sat = 1'b1;
            end else if (w_sum < MIN_V) begin
                o_sum = MIN_V[ACC_BWIDTH-1:0];
                o_sat = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_flex.sv
// Systolic-array cell supporting output-stationary and weight-stationary
// dataflows, with per-operand valids, signed/unsigned MAC and counted drain.
module pe_flex
    import pe_pkg::*;
#(
    parameter int OPND_BWIDTH = 8,
    parameter int ACC_BWIDTH  = 32,
    parameter bit SATURATE    = 1'b1,
    parameter int DRAIN_DEPTH = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ROWE,
    input  logic                   COLE,
    input  logic                   START,
    input  logic                   MODE,
    input  logic                   SIGNED_MODE,
    input  logic                   LOAD_W,
    input  logic                   FLUSH,
    input  logic [OPND_BWIDTH-1:0] OPND1_in,
    input  logic                   OPND1_VLD_in,
    input  logic [OPND_BWIDTH-1:0] OPND2_in,
    input  logic                   OPND2_VLD_in,
    input  logic [ACC_BWIDTH-1:0]  ACC_in,
    input  logic                   ACC_VLD_in,
    output logic [OPND_BWIDTH-1:0] OPND1_out,
    output logic                   OPND1_VLD_out,
    output logic [OPND_BWIDTH-1:0] OPND2_out,
    output logic                   OPND2_VLD_out,
    output logic [ACC_BWIDTH-1:0]  ACC_out,
    output logic                   ACC_VLD_out,
    output logic                   SAT_FLAG,
    output logic                   BUSY
);
    localparam int CNT_W = (DRAIN_DEPTH > 0) ? $clog2(DRAIN_DEPTH + 1) : 1;

    pe_state_t              r_state;
    pe_state_t              w_state_next;
    logic                   r_signed;
    logic                   r_w_loaded;
    logic                   r_sat;
    logic [CNT_W-1:0]       r_drain_cnt;
    logic [ACC_BWIDTH-1:0]  r_acc_buf;
    logic [OPND_BWIDTH-1:0] r_w_buf;
    logic [OPND_BWIDTH-1:0] r_opnd1;
    logic                   r_opnd1_vld;
    logic [OPND_BWIDTH-1:0] r_opnd2;
    logic                   r_opnd2_vld;
    logic [ACC_BWIDTH-1:0]  r_acc_out;
    logic                   r_acc_vld;

    logic                   w_en;
    logic                   w_ws_run;
    logic                   w_os_mac;
    logic                   w_ws_mac;
    logic                   w_drain_last;
    logic [OPND_BWIDTH-1:0] w_mac_b;
    logic [ACC_BWIDTH-1:0]  w_mac_acc;
    logic [ACC_BWIDTH-1:0]  w_mac_sum;
    logic                   w_mac_sat;

    assign w_en         = ROWE & COLE;
    assign w_ws_run     = (r_state == ST_WS_RUN);
    assign w_os_mac     = OPND1_VLD_in & OPND2_VLD_in;
    assign w_ws_mac     = OPND1_VLD_in & ACC_VLD_in;
    assign w_drain_last = (r_drain_cnt == CNT_W'(DRAIN_DEPTH));
    assign w_mac_b      = w_ws_run ? r_w_buf : OPND2_in;
    assign w_mac_acc    = w_ws_run ? ACC_in  : r_acc_buf;

    pe_mac_sat #(
        .OPND_BWIDTH (OPND_BWIDTH),
        .ACC_BWIDTH  (ACC_BWIDTH),
        .SATURATE    (SATURATE)
    ) u_mac (
        .i_a      (OPND1_in),
        .i_b      (w_mac_b),
        .i_acc    (w_mac_acc),
        .i_signed (r_signed),
        .o_sum    (w_mac_sum),
        .o_sat    (w_mac_sat)
    );

    always_ff @(posedge CLK) begin
        if (RST)       r_state <= ST_IDLE;
        else if (w_en) r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (START) w_state_next = (MODE == MODE_WS) ? ST_WS_LOAD : ST_OS_RUN;
            ST_OS_RUN:   if (FLUSH) w_state_next = ST_OS_DRAIN;
            ST_OS_DRAIN: if (w_drain_last) w_state_next = ST_IDLE;
            ST_WS_LOAD: begin
                if (FLUSH)                     w_state_next = ST_IDLE;
                else if (!LOAD_W && r_w_loaded) w_state_next = ST_WS_RUN;
            end
            ST_WS_RUN:   if (FLUSH) w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_signed    <= 1'b0;
            r_w_loaded  <= 1'b0;
            r_sat       <= 1'b0;
            r_drain_cnt <= '0;
            r_acc_buf   <= '0;
            r_w_buf     <= '0;
            r_opnd1     <= '0;
            r_opnd1_vld <= 1'b0;
            r_opnd2     <= '0;
            r_opnd2_vld <= 1'b0;
            r_acc_out   <= '0;
            r_acc_vld   <= 1'b0;
        end else if (w_en) begin
            // NOTE: non-blocking defaults here are overridden by any later assignment in the case below.
            r_opnd1_vld <= 1'b0;
            r_opnd2_vld <= 1'b0;
            r_acc_vld   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_signed <= SIGNED_MODE;
                        r_sat    <= 1'b0;
                        if (MODE == MODE_OS) r_acc_buf  <= '0;
                        else                 r_w_loaded <= 1'b0;
                    end
                end
                ST_OS_RUN: begin
                    r_opnd1     <= OPND1_in;
                    r_opnd1_vld <= OPND1_VLD_in;
                    r_opnd2     <= OPND2_in;
                    r_opnd2_vld <= OPND2_VLD_in;
                    if (w_os_mac) begin
                        r_acc_buf <= w_mac_sum;
                        if (w_mac_sat) r_sat <= 1'b1;
                    end
                    // Drain word 0 is loaded here so it includes a MAC landing with FLUSH.
                    if (FLUSH) begin
                        r_acc_out <= w_os_mac ? w_mac_sum : r_acc_buf;
                        r_acc_vld <= 1'b1;
                    end
                end
                ST_OS_DRAIN: begin
                    if (w_drain_last) begin
                        r_drain_cnt <= '0;
                    end else begin
                        r_acc_out   <= ACC_in;
                        r_acc_vld   <= ACC_VLD_in;
                        r_drain_cnt <= r_drain_cnt + CNT_W'(1);
                    end
                end
                ST_WS_LOAD: begin
                    if (!FLUSH && LOAD_W) begin
                        r_w_buf     <= OPND2_in;
                        r_opnd2     <= r_w_buf;
                        r_opnd2_vld <= 1'b1;
                        r_w_loaded  <= 1'b1;
                    end
                end
                ST_WS_RUN: begin
                    r_opnd1     <= OPND1_in;
                    r_opnd1_vld <= OPND1_VLD_in;
                    if (w_ws_mac) begin
                        r_acc_out <= w_mac_sum;
                        r_acc_vld <= 1'b1;
                        if (w_mac_sat) r_sat <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign OPND1_out     = r_opnd1;
    assign OPND1_VLD_out = r_opnd1_vld;
    assign OPND2_out     = r_opnd2;
    assign OPND2_VLD_out = r_opnd2_vld;
    assign ACC_out       = r_acc_out;
    assign ACC_VLD_out   = r_acc_vld;
    assign SAT_FLAG      = r_sat;
    assign BUSY          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pe_flex.sv
// Directed bench for pe_flex: a saturating 16-bit cell with a 3-deep drain
// and a wrapping 16-bit cell with a 0-deep drain share all inputs.
module tb_pe_flex;
    localparam int OW = 8;
    localparam int AW = 16;

    logic          CLK = 1'b0;
    logic          RST, ROWE, COLE, START, MODE, SIGNED_MODE, LOAD_W, FLUSH;
    logic [OW-1:0] OPND1_in, OPND2_in;
    logic          OPND1_VLD_in, OPND2_VLD_in;
    logic [AW-1:0] ACC_in;
    logic          ACC_VLD_in;

    logic [OW-1:0] d_o1, d_o2, x_o1, x_o2;
    logic          d_o1v, d_o2v, x_o1v, x_o2v;
    logic [AW-1:0] d_acc, x_acc;
    logic          d_accv, d_sat, d_busy, x_accv, x_sat, x_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    pe_flex #(.OPND_BWIDTH(OW), .ACC_BWIDTH(AW), .SATURATE(1'b1), .DRAIN_DEPTH(3)) dut (
        .CLK(CLK), .RST(RST), .ROWE(ROWE), .COLE(COLE), .START(START), .MODE(MODE),
        .SIGNED_MODE(SIGNED_MODE), .LOAD_W(LOAD_W), .FLUSH(FLUSH),
        .OPND1_in(OPND1_in), .OPND1_VLD_in(OPND1_VLD_in),
        .OPND2_in(OPND2_in), .OPND2_VLD_in(OPND2_VLD_in),
        .ACC_in(ACC_in), .ACC_VLD_in(ACC_VLD_in),
        .OPND1_out(d_o1), .OPND1_VLD_out(d_o1v), .OPND2_out(d_o2), .OPND2_VLD_out(d_o2v),
        .ACC_out(d_acc), .ACC_VLD_out(d_accv), .SAT_FLAG(d_sat), .BUSY(d_busy));

    pe_flex #(.OPND_BWIDTH(OW), .ACC_BWIDTH(AW), .SATURATE(1'b0), .DRAIN_DEPTH(0)) dut_wrap (
        .CLK(CLK), .RST(RST), .ROWE(ROWE), .COLE(COLE), .START(START), .MODE(MODE),
        .SIGNED_MODE(SIGNED_MODE), .LOAD_W(LOAD_W), .FLUSH(FLUSH),
        .OPND1_in(OPND1_in), .OPND1_VLD_in(OPND1_VLD_in),
        .OPND2_in(OPND2_in), .OPND2_VLD_in(OPND2_VLD_in),
        .ACC_in(ACC_in), .ACC_VLD_in(ACC_VLD_in),
        .OPND1_out(x_o1), .OPND1_VLD_out(x_o1v), .OPND2_out(x_o2), .OPND2_VLD_out(x_o2v),
        .ACC_out(x_acc), .ACC_VLD_out(x_accv), .SAT_FLAG(x_sat), .BUSY(x_busy));

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ROWE = 1'b1; COLE = 1'b1; START = 1'b0; MODE = 1'b0; SIGNED_MODE = 1'b0;
        LOAD_W = 1'b0; FLUSH = 1'b0;
        OPND1_in = '0; OPND1_VLD_in = 1'b0; OPND2_in = '0; OPND2_VLD_in = 1'b0;
        ACC_in = '0; ACC_VLD_in = 1'b0;
    endtask

    task automatic start_job(input logic mode, input logic sgn);
        START = 1'b1; MODE = mode; SIGNED_MODE = sgn;
        tick();
        START = 1'b0;
    endtask

    task automatic feed(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic fl);
        OPND1_in = a; OPND2_in = b; OPND1_VLD_in = 1'b1; OPND2_VLD_in = 1'b1; FLUSH = fl;
        tick();
        OPND1_VLD_in = 1'b0; OPND2_VLD_in = 1'b0; FLUSH = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        clear_inputs();
        while (d_busy === 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_cmp++;
        if (d_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle_timeout: busy=%b want 0", tag, d_busy);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({d_o1, d_o1v, d_o2, d_o2v, d_acc, d_accv, d_sat, d_busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {d_o1, d_o1v, d_o2, d_o2v, d_acc, d_accv, d_sat, d_busy});
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_os_signed();
        start_job(1'b0, 1'b1);
        feed(8'd3, 8'd4, 1'b0);
        n_cmp++;
        if ({d_o1, d_o1v, d_o2, d_o2v, d_accv} !== {8'd3, 1'b1, 8'd4, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL os_forward: got o1=%0d/%b o2=%0d/%b accv=%b want 3/1 4/1 0",
                     d_o1, d_o1v, d_o2, d_o2v, d_accv);
        end
        feed(8'(-2), 8'd5, 1'b0);
        feed(8'd7, 8'(-1), 1'b1);
        n_cmp++;
        if ({d_acc, d_accv, d_busy} !== {16'(-5), 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL os_drain0: got acc=%0d v=%b busy=%b want -5 1 1", $signed(d_acc), d_accv, d_busy);
        end
        n_cmp++;
        if ({x_acc, x_accv} !== {16'(-5), 1'b1}) begin
            n_bad++;
            $display("FAIL os_wrap_drain0: got acc=%0d v=%b want -5 1", $signed(x_acc), x_accv);
        end
        ACC_in = 16'd100; ACC_VLD_in = 1'b1;
        tick();
        n_cmp++;
        if ({d_acc, d_accv, d_o1v, d_o2v, d_busy} !== {16'd100, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL os_drain1: got acc=%0d v=%b o1v=%b o2v=%b busy=%b want 100 1 0 0 1",
                     d_acc, d_accv, d_o1v, d_o2v, d_busy);
        end
        n_cmp++;
        if ({x_accv, x_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL os_depth0_done: got accv=%b busy=%b want 0 0", x_accv, x_busy);
        end
        ACC_in = 16'd200;
        tick();
        ACC_in = 16'd300; ACC_VLD_in = 1'b0;
        tick();
        n_cmp++;
        if ({d_acc, d_accv, d_busy} !== {16'd300, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL os_drain3: got acc=%0d v=%b busy=%b want 300 0 1", d_acc, d_accv, d_busy);
        end
        tick();
        n_cmp++;
        if ({d_accv, d_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL os_drain_end: got accv=%b busy=%b want 0 0", d_accv, d_busy);
        end
        clear_inputs();
    endtask

    task automatic test_skewed_valids();
        start_job(1'b0, 1'b1);
        OPND1_in = 8'd5; OPND1_VLD_in = 1'b1; OPND2_in = 8'd6; OPND2_VLD_in = 1'b0;
        tick();
        n_cmp++;
        if ({d_o1, d_o1v, d_o2v} !== {8'd5, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL skew_n: got o1=%0d/%b o2v=%b want 5/1 0", d_o1, d_o1v, d_o2v);
        end
        OPND1_in = 8'd0; OPND1_VLD_in = 1'b0; OPND2_in = 8'd7; OPND2_VLD_in = 1'b1;
        tick();
        n_cmp++;
        if ({d_o1v, d_o2, d_o2v} !== {1'b0, 8'd7, 1'b1}) begin
            n_bad++;
            $display("FAIL skew_n1: got o1v=%b o2=%0d/%b want 0 7/1", d_o1v, d_o2, d_o2v);
        end
        OPND2_VLD_in = 1'b0; FLUSH = 1'b1;
        tick();
        n_cmp++;
        if ({d_acc, d_accv} !== {16'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL skew_acc: got acc=%0d v=%b want 0 1", $signed(d_acc), d_accv);
        end
        wait_idle("skew");
    endtask

    task automatic test_saturation();
        start_job(1'b0, 1'b0);
        feed(8'd255, 8'd255, 1'b0);
        feed(8'd255, 8'd255, 1'b1);
        n_cmp++;
        if ({d_acc, d_accv, d_sat} !== {16'h7FFF, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL sat_clamp: got acc=%h v=%b sat=%b want 7fff 1 1", d_acc, d_accv, d_sat);
        end
        n_cmp++;
        if ({x_acc, x_sat} !== {16'hFC02, 1'b0}) begin
            n_bad++;
            $display("FAIL sat_wrap: got acc=%h sat=%b want fc02 0", x_acc, x_sat);
        end
        wait_idle("sat");
        n_cmp++;
        if (d_sat !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_sticky: got %b want 1", d_sat);
        end
        start_job(1'b0, 1'b1);
        n_cmp++;
        if (d_sat !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_clear_on_start: got %b want 0", d_sat);
        end
        FLUSH = 1'b1;
        tick();
        wait_idle("sat2");
    endtask

    task automatic test_ws_flow();
        LOAD_W = 1'b1;
        tick();
        n_cmp++;
        if (d_o2v !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_load_w_ignored: got o2v=%b want 0", d_o2v);
        end
        LOAD_W = 1'b0;
        start_job(1'b1, 1'b1);
        LOAD_W = 1'b1; OPND2_in = 8'd9;
        tick();
        OPND2_in = 8'd6;
        tick();
        n_cmp++;
        if ({d_o2, d_o2v} !== {8'd9, 1'b1}) begin
            n_bad++;
            $display("FAIL ws_shift: got o2=%0d/%b want 9/1", d_o2, d_o2v);
        end
        LOAD_W = 1'b0;
        tick();
        OPND1_in = 8'(-3); OPND1_VLD_in = 1'b1; ACC_in = 16'd10; ACC_VLD_in = 1'b1;
        tick();
        n_cmp++;
        if ({d_acc, d_accv, d_o1, d_o1v, d_o2v} !== {16'(-8), 1'b1, 8'hFD, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL ws_mac: got acc=%0d v=%b o1=%h/%b o2v=%b want -8 1 fd/1 0",
                     $signed(d_acc), d_accv, d_o1, d_o1v, d_o2v);
        end
        ACC_VLD_in = 1'b0;
        tick();
        n_cmp++;
        if (d_accv !== 1'b0) begin
            n_bad++;
            $display("FAIL ws_no_acc_vld: got v=%b want 0", d_accv);
        end
        OPND1_in = 8'd4; ACC_in = 16'(-100); ACC_VLD_in = 1'b1; FLUSH = 1'b1;
        tick();
        n_cmp++;
        if ({d_acc, d_accv, d_busy} !== {16'(-76), 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL ws_flush_last: got acc=%0d v=%b busy=%b want -76 1 0",
                     $signed(d_acc), d_accv, d_busy);
        end
        clear_inputs();
        start_job(1'b1, 1'b0);
        FLUSH = 1'b1;
        tick();
        n_cmp++;
        if ({d_busy, d_accv} !== 2'b00) begin
            n_bad++;
            $display("FAIL ws_load_abort: got busy=%b accv=%b want 0 0", d_busy, d_accv);
        end
        clear_inputs();
    endtask

    task automatic test_enable_gating();
        start_job(1'b0, 1'b1);
        feed(8'd2, 8'd3, 1'b0);
        COLE = 1'b0; FLUSH = 1'b1;
        OPND1_in = 8'd10; OPND2_in = 8'd10; OPND1_VLD_in = 1'b1; OPND2_VLD_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({d_o1, d_o1v, d_o2, d_busy} !== {8'd2, 1'b1, 8'd3, 1'b1}) begin
                n_bad++;
                $display("FAIL en_hold_%0d: got o1=%0d/%b o2=%0d busy=%b want 2/1 3 1",
                         i, d_o1, d_o1v, d_o2, d_busy);
            end
        end
        COLE = 1'b1; FLUSH = 1'b0; START = 1'b1; MODE = 1'b1;
        OPND1_in = 8'd1; OPND2_in = 8'(-4);
        tick();
        START = 1'b0; MODE = 1'b0;
        n_cmp++;
        if ({d_o1, d_o1v, d_o2, d_o2v} !== {8'd1, 1'b1, 8'hFC, 1'b1}) begin
            n_bad++;
            $display("FAIL en_resume: got o1=%0d/%b o2=%h/%b want 1/1 fc/1", d_o1, d_o1v, d_o2, d_o2v);
        end
        OPND1_VLD_in = 1'b0; OPND2_VLD_in = 1'b0; FLUSH = 1'b1;
        tick();
        n_cmp++;
        if ({d_acc, d_accv} !== {16'd2, 1'b1}) begin
            n_bad++;
            $display("FAIL en_acc: got acc=%0d v=%b want 2 1", $signed(d_acc), d_accv);
        end
        wait_idle("en");
    endtask

    task automatic test_reset_mid_drain();
        start_job(1'b0, 1'b1);
        feed(8'd1, 8'd1, 1'b1);
        ACC_in = 16'd55; ACC_VLD_in = 1'b1;
        tick();
        n_cmp++;
        if ({d_acc, d_accv, d_busy} !== {16'd55, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL rst_pre_drain1: got acc=%0d v=%b busy=%b want 55 1 1", d_acc, d_accv, d_busy);
        end
        RST = 1'b1; COLE = 1'b0;
        tick();
        n_cmp++;
        if ({d_o1, d_o1v, d_o2, d_o2v, d_acc, d_accv, d_sat, d_busy} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_drain: got %h want 0",
                     {d_o1, d_o1v, d_o2, d_o2v, d_acc, d_accv, d_sat, d_busy});
        end
        RST = 1'b0; COLE = 1'b1;
        tick();
        n_cmp++;
        if ({d_busy, d_accv} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_stays_idle: got busy=%b accv=%b want 0 0", d_busy, d_accv);
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        clear_inputs();
        test_reset();
        test_os_signed();
        test_skewed_valids();
        test_saturation();
        test_ws_flow();
        test_enable_gating();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
